transmit_engine: RTL and testbench
==================================

Name: transmit_engine

Overview:
- UART transmit path and counterpart of the receive engine, under the same bus-side control (eight, pen, even, k).
- Accepts one byte per load strobe from the TramelBlaze output port and serialises it LSB-first on tx.
- Each frame is always 11 bit-times long.
- Raises tx_rdy when it can accept the next byte; tx_rdy feeds the UART status / interrupt logic.

Parameters:
- FRAME_BITS, 11, bit-times per frame, including start, data, parity and stop/fill.
- K_W, 19, width of the baud divisor k.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- load  in  1  write strobe; one-cycle pulse from the output-port decode
- data_in  in  8  byte to send; bit 7 ignored when eight=0
- eight  in  1  1 = 8 data bits, 0 = 7 data bits
- pen  in  1  parity enable
- even  in  1  1 = even parity, 0 = odd parity
- k  in  19  bit period minus one, in clk cycles
- tx  out  1  serial line; idle/mark = 1
- tx_rdy  out  1  1 = idle and ready for load

Behaviour:
- Reset, synchronous and active-high:
  - tx=1, tx_rdy=1.
  - Shift register all ones.
  - doit=0, load_d=0.
  - Bit-time counter and bit counter = 0.
  - Reset mid-frame aborts the frame; tx is 1 at the next edge.
- Load acceptance:
  - Edge N with load=1 and tx_rdy=1: tx_rdy<=0, data_reg<=data_in, load_d<=1.
  - load while tx_rdy=0 is ignored completely; data_reg is unchanged.
- Frame build, edge N+1 (load_d=1):
  - shift register <= {1, b10, b9, data_reg[6:0], 0}, LSB sent first.
  - doit<=1; both counters cleared; load_d<=0.
  - eight, pen and even are sampled only at this edge.
- Bits b9/b10 by {eight,pen}:
  - 00 (7N1): b9=1, b10=1.
  - 01 (7P1): b9=P7, b10=1.
  - 10 (8N1): b9=data_reg[7], b10=1.
  - 11 (8P1): b9=data_reg[7], b10=P8.
- Parity:
  - P7 = ^data_reg[6:0], P8 = ^data_reg[7:0].
  - even=1 uses P as computed; even=0 uses ~P.
- Output timing: tx = shift_reg[0], registered, so the start bit (0) appears from edge N+1.
- Bit-time counter:
  - Counts only while doit=1.
  - btu = (count==k); count returns to 0 on btu, so each bit lasts exactly k+1 clocks.
  - k=0 gives one clock per bit.
  - k must be stable during a frame; a mid-frame change takes effect immediately and is not protected.
- Shifting:
  - On each btu the shift register shifts right and fills the MSB with 1.
  - bit_count increments on each btu.
- Done:
  - done = doit & btu & (bit_count==FRAME_BITS-1).
  - On the done edge: doit<=0, tx_rdy<=1, counters<=0.
  - tx is then 1 (register all ones), so the line sits at idle.
- Busy window: from edge N, tx_rdy stays 0 for 1 + 11*(k+1) cycles.
- Simultaneous events:
  - load in the same cycle as done is ignored, because tx_rdy is still 0.
  - rst has priority over load and done.
- States (2-bit): IDLE (tx_rdy=1) -> LOAD (load_d) -> SEND (doit) -> IDLE on done.
  - No other transitions except via rst.
  - Unused encoding goes to IDLE.

Decomposition:
- Shared package uart_pkg holds:
  - FRAME_BITS=11 and K_W=19.
  - Mode encodings MODE_7N1=2'b00, MODE_7P1=2'b01, MODE_8N1=2'b10, MODE_8P1=2'b11.
  - The state encoding.
- One natural sub-module: bit_time_counter (inputs clk, rst, en, k; output btu).
  - Written so the receive side can later reuse it with k>>1 selection external.
- Parity/b9/b10 select stays inline.

Test Plan:
- 8N1, k=9, load data_in=8'h55:
  - tx_rdy falls at the next edge.
  - tx sequence, 10 clks each: 0,1,0,1,0,1,0,1,0,1,1.
  - tx_rdy rises 111 clks after the load edge.
- 7P1 even, data 8'h41 -> b9=0; repeat with odd -> b9=1. Frame is 0,1,0,0,0,0,0,1,b9,1,1.
- 8P1, data 8'h03:
  - even -> b10=0; odd -> b10=1.
  - Data 8'h07 with even -> b10=1.
  - Bit 11 is always 1.
- Second load pulse mid-frame (data 8'hAA during 8'h55 frame) -> frame unchanged, no second frame.
- Load asserted in the done cycle -> ignored.
- Load one cycle after tx_rdy rises -> new start bit 2 cycles later.
- rst pulse during bit 5 -> tx=1, tx_rdy=1 next edge.
- Subsequent load with k=0 -> 11-cycle frame, each bit one clock.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART constants, mode encodings and transmit state encoding.
package uart_pkg;
    localparam int FRAME_BITS = 11;
    localparam int K_W = 19;
    localparam logic [1:0] MODE_7N1 = 2'b00;
    localparam logic [1:0] MODE_7P1 = 2'b01;
    localparam logic [1:0] MODE_8N1 = 2'b10;
    localparam logic [1:0] MODE_8P1 = 2'b11;
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_LOAD = 2'b01,
        ST_SEND = 2'b10
    } state_e;
endpackage

// File: rtl/bit_time_counter.sv
// bit_time_counter: pulses btu every k+1 enabled clocks; holds at zero while disabled.
module bit_time_counter
    import uart_pkg::*;
#(
    parameter int W = K_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [W-1:0] k,
    output logic         btu
);
    logic [W-1:0] count_q, count_d;
    assign btu = en & (count_q == k);
    always_comb count_d = (!en || btu) ? '0 : count_q + 1'b1;
    always_ff @(posedge clk) begin
        if (rst) count_q <= '0;
        else     count_q <= count_d;
    end
endmodule

// File: rtl/transmit_engine.sv
// transmit_engine: UART transmitter, one byte per load strobe, fixed 11 bit-time frames LSB-first.
module transmit_engine
    import uart_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    input  logic           load,
    input  logic [7:0]     data_in,
    input  logic           eight,
    input  logic           pen,
    input  logic           even,
    input  logic [K_W-1:0] k,
    output logic           tx,
    output logic           tx_rdy
);
    state_e                  state_q, state_d;
    logic [7:0]              data_q, data_d;
    logic [FRAME_BITS-1:0]   shift_q, shift_d;
    logic [3:0]              bit_count_q, bit_count_d;
    logic                    doit, btu, done, p7, p8, b9, b10;
    logic [1:0]              mode;
    assign doit   = (state_q == ST_SEND);
    assign done   = doit & btu & (bit_count_q == 4'(FRAME_BITS - 1));
    assign tx     = shift_q[0];
    assign tx_rdy = (state_q == ST_IDLE);
    assign mode   = {eight, pen};
    // Parity is inverted for odd mode; b9/b10 fall back to mark (1) as fill bits.
    assign p7  = even ? ^data_q[6:0] : ~^data_q[6:0];
    assign p8  = even ? ^data_q : ~^data_q;
    assign b9  = (mode == MODE_7N1) ? 1'b1 : (mode == MODE_7P1) ? p7 : data_q[7];
    assign b10 = (mode == MODE_8P1) ? p8 : 1'b1;
    bit_time_counter #(.W(K_W)) u_btc (
        .clk (clk),
        .rst (rst),
        .en  (doit),
        .k   (k),
        .btu (btu)
    );
    always_comb begin
        state_d     = state_q;
        data_d      = data_q;
        shift_d     = shift_q;
        bit_count_d = bit_count_q;
        case (state_q)
            ST_IDLE: begin
                state_d = load ? ST_LOAD : ST_IDLE;
                data_d  = load ? data_in : data_q;
            end
            ST_LOAD: begin
                state_d     = ST_SEND;
                shift_d     = {1'b1, b10, b9, data_q[6:0], 1'b0};
                bit_count_d = '0;
            end
            ST_SEND: begin
                state_d     = done ? ST_IDLE : ST_SEND;
                shift_d     = btu ? {1'b1, shift_q[FRAME_BITS-1:1]} : shift_q;
                bit_count_d = done ? '0 : btu ? bit_count_q + 1'b1 : bit_count_q;
            end
            default: state_d = ST_IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            data_q      <= '0;
            shift_q     <= '1;
            bit_count_q <= '0;
        end else begin
            state_q     <= state_d;
            data_q      <= data_d;
            shift_q     <= shift_d;
            bit_count_q <= bit_count_d;
        end
    end
endmodule

// File: tb/tb_transmit_engine.sv
// tb_transmit_engine: table-driven frame checks plus hand-written reset and back-to-back sequences.
module tb_transmit_engine;
    logic        clk = 0;
    logic        rst, load, eight, pen, even, tx, tx_rdy;
    logic [7:0]  data_in;
    logic [18:0] k;
    int          passed = 0;
    int          total = 0;

    typedef struct {
        logic [7:0]  data;
        logic        eight;
        logic        pen;
        logic        even;
        int          k;
        logic [10:0] exp;
        int          poke;
        int          idle;
    } vec_t;

    vec_t vecs[9];
    vec_t vk0;

    transmit_engine dut (
        .clk     (clk),
        .rst     (rst),
        .load    (load),
        .data_in (data_in),
        .eight   (eight),
        .pen     (pen),
        .even    (even),
        .k       (k),
        .tx      (tx),
        .tx_rdy  (tx_rdy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic ok, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (ok) passed++;
        else $display("FAIL %s: got %0h want %0h", nm, act, want);
    endtask

    // Caller must be positioned just after a negedge; leaves the bench after a negedge.
    task automatic run_frame(input vec_t v, input string nm);
        int cyc;
        logic bad;
        logic [1:0] got;
        data_in = v.data;
        eight = v.eight;
        pen = v.pen;
        even = v.even;
        k = 19'(v.k);
        load = 1;
        @(negedge clk);
        load = 0;
        chk({nm, " accept"}, tx_rdy === 1'b0 && tx === 1'b1, {30'b0, tx_rdy, tx}, 32'h1);
        cyc = 0;
        for (int i = 0; i < 11; i++) begin
            bad = 0;
            got = 0;
            for (int c = 0; c <= v.k; c++) begin
                @(negedge clk);
                if (tx !== v.exp[i] || tx_rdy !== 1'b0) begin
                    bad = 1;
                    got = {tx_rdy, tx};
                end
                if (cyc == 0) begin
                    eight = ~eight;
                    pen = ~pen;
                    even = ~even;
                end
                load = (cyc == v.poke);
                if (cyc == v.poke) data_in = 8'hAA;
                cyc++;
            end
            chk($sformatf("%s bit%0d", nm, i), !bad, {30'b0, got}, {31'b0, v.exp[i]});
        end
        @(negedge clk);
        load = 0;
        chk({nm, " done"}, tx_rdy === 1'b1 && tx === 1'b1, {30'b0, tx_rdy, tx}, 32'h3);
        for (int j = 0; j < v.idle; j++) begin
            @(negedge clk);
            chk($sformatf("%s idle%0d", nm, j), tx_rdy === 1'b1 && tx === 1'b1, {30'b0, tx_rdy, tx}, 32'h3);
        end
    endtask

    initial begin
        vecs[0] = '{8'h55, 1'b1, 1'b0, 1'b0, 9, 11'b11010101010, -1, 0};
        vecs[1] = '{8'h41, 1'b0, 1'b1, 1'b1, 2, 11'b11010000010, -1, 2};
        vecs[2] = '{8'h41, 1'b0, 1'b1, 1'b0, 2, 11'b11110000010, -1, 2};
        vecs[3] = '{8'h03, 1'b1, 1'b1, 1'b1, 1, 11'b10000000110, -1, 2};
        vecs[4] = '{8'h03, 1'b1, 1'b1, 1'b0, 1, 11'b11000000110, -1, 2};
        vecs[5] = '{8'h07, 1'b1, 1'b1, 1'b1, 1, 11'b11000001110, -1, 2};
        vecs[6] = '{8'hFF, 1'b0, 1'b0, 1'b0, 1, 11'b11111111110, -1, 2};
        vecs[7] = '{8'h55, 1'b1, 1'b0, 1'b0, 9, 11'b11010101010, 30, 12};
        vecs[8] = '{8'h12, 1'b0, 1'b0, 1'b0, 3, 11'b11100100100, 43, 6};
        vk0     = '{8'hC3, 1'b1, 1'b0, 1'b0, 0, 11'b11110000110, -1, 2};

        rst = 1;
        load = 0;
        data_in = 0;
        eight = 0;
        pen = 0;
        even = 0;
        k = 0;
        repeat (2) @(negedge clk);
        chk("reset", tx === 1'b1 && tx_rdy === 1'b1, {30'b0, tx_rdy, tx}, 32'h3);
        rst = 0;

        for (int n = 0; n < 9; n++) run_frame(vecs[n], $sformatf("v%0d", n));

        data_in = 8'h00;
        eight = 1;
        pen = 0;
        k = 19'd9;
        load = 1;
        @(negedge clk);
        load = 0;
        repeat (53) @(negedge clk);
        chk("pre_rst bit5", tx === 1'b0 && tx_rdy === 1'b0, {30'b0, tx_rdy, tx}, 32'h0);
        rst = 1;
        @(negedge clk);
        chk("mid_rst", tx === 1'b1 && tx_rdy === 1'b1, {30'b0, tx_rdy, tx}, 32'h3);
        rst = 0;
        begin
            logic bad;
            bad = 0;
            repeat (15) begin
                @(negedge clk);
                if (tx !== 1'b1 || tx_rdy !== 1'b1) bad = 1;
            end
            chk("post_rst idle", !bad, {31'b0, bad}, 32'h0);
        end

        run_frame(vk0, "k0");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
